// File: rtl/ulpi_pkg.sv
// ---------------------------------------------------------------------------
// ulpi_pkg
// Shared ULPI definitions used by ulpi_ctrl and ulpi_reg_rw:
//   - ulpi_reg_state_t : register-access engine state encoding
//   - TX CMD prefixes for immediate register write/read
//   - idle value driven on the ULPI data bus by the link
//   - ulpi_txcmd_reg() : builds an immediate register TX CMD byte
// ---------------------------------------------------------------------------
package ulpi_pkg;

  typedef enum logic [3:0] {
    ULPI_REG_STATE_IDLE,
    ULPI_REG_STATE_WR_CMD,
    ULPI_REG_STATE_WR_DATA,
    ULPI_REG_STATE_WR_STP,
    ULPI_REG_STATE_RD_CMD,
    ULPI_REG_STATE_RD_TURN,
    ULPI_REG_STATE_RD_DATA,
    ULPI_REG_STATE_RD_TURN_BACK,
    ULPI_REG_STATE_WAIT_DIR_LOW,
    ULPI_REG_STATE_ABORT_STP
  } ulpi_reg_state_t;

  localparam logic [1:0] ULPI_TXCMD_REGWR = 2'b10;
  localparam logic [1:0] ULPI_TXCMD_REGRD = 2'b11;
  localparam logic [7:0] ULPI_DATA_IDLE   = 8'h00;

  function automatic logic [7:0] ulpi_txcmd_reg(input logic       write,
                                                input logic [5:0] addr);
    return {(write ? ULPI_TXCMD_REGWR : ULPI_TXCMD_REGRD), addr};
  endfunction

endpackage

// File: rtl/ulpi_reg_rw.sv
// ---------------------------------------------------------------------------
// ulpi_reg_rw
// Link-side ULPI register-access engine. Executes one immediate register
// write or read per accepted request and returns a one-cycle response.
//
// Ports:
//   i_clk          ULPI 60 MHz clock, rising edge
//   i_rst          synchronous reset, active-low
//   i_en           bus granted by ulpi_ctrl; gates new accepts only
//   i_req_valid    request present
//   o_req_ready    request accepted when high together with i_req_valid
//   i_req_write    1 = register write, 0 = register read
//   i_req_addr     immediate register address
//   i_req_wdata    write data
//   o_rsp_valid    one-cycle response strobe
//   o_rsp_rdata    read data (0 for writes and aborted transactions)
//   o_rsp_err      transaction aborted (dir preemption or timeout)
//   i_dir, i_nxt   ULPI dir / nxt from PHY
//   o_stp          ULPI stp to PHY
//   i_data         ULPI data from PHY
//   o_data         ULPI data to PHY, 0x00 when not driving
//
// NXT_TIMEOUT: cycles allowed in a wait state before aborting; 0 disables.
// ---------------------------------------------------------------------------
module ulpi_reg_rw
  import ulpi_pkg::*;
#(
  parameter int unsigned NXT_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_write,
  input  logic [5:0] i_req_addr,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata,
  output logic       o_rsp_err,
  input  logic       i_dir,
  input  logic       i_nxt,
  output logic       o_stp,
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  // Counter holds 0 .. NXT_TIMEOUT-1; the abort fires in the cycle that
  // would otherwise be the NXT_TIMEOUT-th cycle spent waiting.
  localparam int unsigned    CNT_W      = (NXT_TIMEOUT > 1) ? $clog2(NXT_TIMEOUT) : 1;
  localparam bit             TIMEOUT_ON = (NXT_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_ON ? CNT_W'(NXT_TIMEOUT - 1) : '0;

  ulpi_reg_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             cnt_en;
  logic             timeout_hit;
  logic             accept;

  // Ready is also gated by i_rst so the handshake never claims an accept
  // in a cycle where reset wins.
  assign o_req_ready = i_rst & (state_q == ULPI_REG_STATE_IDLE) & i_en & ~i_dir;
  assign accept      = o_req_ready & i_req_valid;
  assign timeout_hit = TIMEOUT_ON && (cnt_q == CNT_LAST);

  always_comb begin
    case (state_q)
      ULPI_REG_STATE_WR_CMD,
      ULPI_REG_STATE_WR_DATA,
      ULPI_REG_STATE_RD_CMD,
      ULPI_REG_STATE_RD_TURN,
      ULPI_REG_STATE_RD_TURN_BACK: cnt_en = 1'b1;
      default:                     cnt_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 8'h00;
    rsp_err_d   = 1'b0;
    case (state_q)
      ULPI_REG_STATE_IDLE: begin
        if (accept) begin
          cmd_d   = ulpi_txcmd_reg(i_req_write, i_req_addr);
          wdata_d = i_req_wdata;
          state_d = i_req_write ? ULPI_REG_STATE_WR_CMD : ULPI_REG_STATE_RD_CMD;
        end
      end
      // dir wins over nxt: a PHY that turns the bus around owns it.
      ULPI_REG_STATE_WR_CMD: begin
        if (i_dir)            state_d = ULPI_REG_STATE_WAIT_DIR_LOW;
        else if (i_nxt)       state_d = ULPI_REG_STATE_WR_DATA;
        else if (timeout_hit) state_d = ULPI_REG_STATE_ABORT_STP;
      end
      ULPI_REG_STATE_WR_DATA: begin
        if (i_dir)            state_d = ULPI_REG_STATE_WAIT_DIR_LOW;
        else if (i_nxt)       state_d = ULPI_REG_STATE_WR_STP;
        else if (timeout_hit) state_d = ULPI_REG_STATE_ABORT_STP;
      end
      ULPI_REG_STATE_WR_STP: begin
        state_d     = ULPI_REG_STATE_IDLE;
        rsp_valid_d = 1'b1;
      end
      ULPI_REG_STATE_RD_CMD: begin
        if (i_dir)            state_d = ULPI_REG_STATE_WAIT_DIR_LOW;
        else if (i_nxt)       state_d = ULPI_REG_STATE_RD_TURN;
        else if (timeout_hit) state_d = ULPI_REG_STATE_ABORT_STP;
      end
      ULPI_REG_STATE_RD_TURN: begin
        if (i_dir)            state_d = ULPI_REG_STATE_RD_DATA;
        else if (timeout_hit) state_d = ULPI_REG_STATE_ABORT_STP;
      end
      ULPI_REG_STATE_RD_DATA: begin
        rdata_d = i_data;
        state_d = ULPI_REG_STATE_RD_TURN_BACK;
      end
      ULPI_REG_STATE_RD_TURN_BACK: begin
        if (!i_dir) begin
          state_d     = ULPI_REG_STATE_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata_q;
        end else if (timeout_hit) begin
          state_d = ULPI_REG_STATE_ABORT_STP;
        end
      end
      ULPI_REG_STATE_ABORT_STP: begin
        state_d = ULPI_REG_STATE_WAIT_DIR_LOW;
      end
      ULPI_REG_STATE_WAIT_DIR_LOW: begin
        if (!i_dir) begin
          state_d     = ULPI_REG_STATE_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      default: state_d = ULPI_REG_STATE_IDLE;
    endcase
  end

  // Counter restarts on every state change so each wait phase gets the
  // full budget.
  assign cnt_d = ((state_d != state_q) || !cnt_en) ? '0 : cnt_q + CNT_W'(1);

  // Control and response registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= ULPI_REG_STATE_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Latched request fields and captured read data; only observed in states
  // reached after they are written, so they need no reset.
  always_ff @(posedge i_clk) begin
    cmd_q   <= cmd_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  always_comb begin
    case (state_q)
      ULPI_REG_STATE_WR_CMD,
      ULPI_REG_STATE_RD_CMD:  o_data = cmd_q;
      ULPI_REG_STATE_WR_DATA: o_data = wdata_q;
      default:                o_data = ULPI_DATA_IDLE;
    endcase
  end

  assign o_stp       = (state_q == ULPI_REG_STATE_WR_STP) ||
                       (state_q == ULPI_REG_STATE_ABORT_STP);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ulpi_reg_rw.sv
// ---------------------------------------------------------------------------
// tb_ulpi_reg_rw
// Transactions are described as per-cycle PHY behaviour plus the expected
// link bus values; accept cycles push the expected response into a queue
// that a separate monitor drains whenever o_rsp_valid is seen.
// ---------------------------------------------------------------------------
module tb_ulpi_reg_rw;

  localparam int unsigned T = 8;

  logic       clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_en = 1'b0;
  logic       i_req_valid = 1'b0;
  logic       i_req_write = 1'b0;
  logic [5:0] i_req_addr = 6'h00;
  logic [7:0] i_req_wdata = 8'h00;
  logic       i_dir = 1'b0;
  logic       i_nxt = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_req_ready, o_rsp_valid, o_rsp_err, o_stp;
  logic [7:0] o_rsp_rdata, o_data;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ulpi_reg_rw #(.NXT_TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .i_dir(i_dir), .i_nxt(i_nxt), .o_stp(o_stp), .i_data(i_data), .o_data(o_data)
  );

  typedef struct {
    logic       rst_n, en, vld, wr;
    logic [5:0] addr;
    logic [7:0] wd;
    logic       dir, nxt;
    logic [7:0] din;
    logic [7:0] x_data;
    logic       x_stp, x_ready, x_rst;
    int         lat;
    logic       r_err;
    logic [7:0] r_data;
  } rec_t;

  typedef struct {
    int         at;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  rec_t sched[$];
  exp_t expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] cmd_of(input logic wr, input logic [5:0] addr);
    logic [1:0] pfx;
    pfx = wr ? 2'b10 : 2'b11;
    return {pfx, addr};
  endfunction

  function automatic rec_t base();
    rec_t r;
    r.rst_n = 1'b1; r.en = 1'b1; r.vld = 1'b0; r.wr = 1'($urandom);
    r.addr = 6'($urandom); r.wd = 8'($urandom);
    r.dir = 1'b0; r.nxt = 1'b0; r.din = 8'($urandom);
    r.x_data = 8'h00; r.x_stp = 1'b0; r.x_ready = 1'b1; r.x_rst = 1'b0;
    r.lat = -1; r.r_err = 1'b0; r.r_data = 8'h00;
    return r;
  endfunction

  // A cycle inside a transaction: i_en wiggles freely, ready must stay low.
  function automatic rec_t busy(input logic [7:0] xd);
    rec_t r;
    r = base();
    r.en = 1'($urandom);
    r.x_ready = 1'b0;
    r.x_data = xd;
    return r;
  endfunction

  task automatic push_accept(input logic wr, input logic [5:0] addr, input logic [7:0] wd,
                             input int lat, input logic err, input logic [7:0] rdata);
    rec_t r;
    r = base();
    r.vld = 1'b1; r.wr = wr; r.addr = addr; r.wd = wd;
    r.lat = lat; r.r_err = err; r.r_data = rdata;
    sched.push_back(r);
  endtask

  // Write: CMD shown dc stalled cycles + nxt cycle, data likewise, one stp cycle.
  task automatic add_write(input logic [5:0] addr, input logic [7:0] wd, input int dc, input int dd);
    rec_t r;
    logic [7:0] c;
    c = cmd_of(1'b1, addr);
    push_accept(1'b1, addr, wd, dc + dd + 4, 1'b0, 8'h00);
    repeat (dc) sched.push_back(busy(c));
    r = busy(c); r.nxt = 1'b1; sched.push_back(r);
    repeat (dd) sched.push_back(busy(wd));
    r = busy(wd); r.nxt = 1'b1; sched.push_back(r);
    r = busy(8'h00); r.x_stp = 1'b1; sched.push_back(r);
  endtask

  // Read: CMD phase, PHY raises dir after dt cycles, drives data, holds dir db cycles.
  task automatic add_read(input logic [5:0] addr, input logic [7:0] rd,
                          input int dc, input int dt, input int db);
    rec_t r;
    logic [7:0] c;
    c = cmd_of(1'b0, addr);
    push_accept(1'b0, addr, 8'h00, dc + dt + db + 5, 1'b0, rd);
    repeat (dc) sched.push_back(busy(c));
    r = busy(c); r.nxt = 1'b1; sched.push_back(r);
    repeat (dt) sched.push_back(busy(8'h00));
    r = busy(8'h00); r.dir = 1'b1; sched.push_back(r);
    r = busy(8'h00); r.dir = 1'b1; r.din = rd; sched.push_back(r);
    repeat (db) begin
      r = busy(8'h00); r.dir = 1'b1; sched.push_back(r);
    end
    sched.push_back(busy(8'h00));
  endtask

  // PHY grabs the bus for h cycles, either in the CMD phase or in the write data phase.
  task automatic add_preempt(input logic wr, input logic [5:0] addr, input logic [7:0] wd,
                             input int dc, input logic in_data, input int dd, input int h);
    rec_t r;
    logic [7:0] c;
    c = cmd_of(wr, addr);
    push_accept(wr, addr, wd, in_data ? (dc + dd + h + 3) : (dc + h + 2), 1'b1, 8'h00);
    repeat (dc) sched.push_back(busy(c));
    if (in_data) begin
      r = busy(c); r.nxt = 1'b1; sched.push_back(r);
      repeat (dd) sched.push_back(busy(wd));
      r = busy(wd); r.dir = 1'b1;
    end else begin
      r = busy(c); r.dir = 1'b1; r.nxt = 1'($urandom);
    end
    sched.push_back(r);
    repeat (h - 1) begin
      r = busy(8'h00); r.dir = 1'b1; sched.push_back(r);
    end
    sched.push_back(busy(8'h00));
  endtask

  // nxt never comes: T cycles of CMD, one stp cycle, then err response.
  task automatic add_timeout(input logic wr, input logic [5:0] addr, input logic [7:0] wd);
    rec_t r;
    logic [7:0] c;
    c = cmd_of(wr, addr);
    push_accept(wr, addr, wd, T + 3, 1'b1, 8'h00);
    repeat (T) sched.push_back(busy(c));
    r = busy(8'h00); r.x_stp = 1'b1; sched.push_back(r);
    sched.push_back(busy(8'h00));
  endtask

  // Idle cycles; a request may be presented only where it must be refused.
  task automatic add_idle(input int n);
    rec_t r;
    repeat (n) begin
      r = base();
      r.vld = 1'($urandom);
      if (r.vld) begin
        if ($urandom_range(0, 1) == 0) r.dir = 1'b1; else r.en = 1'b0;
        r.x_ready = 1'b0;
      end else begin
        r.en = 1'($urandom);
        r.dir = 1'($urandom);
        r.x_ready = r.en & ~r.dir;
      end
      sched.push_back(r);
    end
  endtask

  task automatic add_reset(input int n);
    rec_t r;
    repeat (n) begin
      r = base();
      r.rst_n = 1'b0; r.en = 1'($urandom); r.vld = 1'($urandom);
      r.x_ready = 1'b0; r.x_rst = 1'b1;
      sched.push_back(r);
    end
  endtask

  task automatic add_reset_mid_read(input logic [5:0] addr, input logic [7:0] rd);
    rec_t r;
    push_accept(1'b0, addr, 8'h00, -1, 1'b0, 8'h00);
    r = busy(cmd_of(1'b0, addr)); r.nxt = 1'b1; sched.push_back(r);
    r = busy(8'h00); r.dir = 1'b1; sched.push_back(r);
    r = busy(8'h00); r.dir = 1'b1; r.din = rd; sched.push_back(r);
    r = busy(8'h00); r.dir = 1'b1; r.rst_n = 1'b0; r.en = 1'b0; r.vld = 1'b1;
    sched.push_back(r);
    repeat (3) begin
      r = base(); r.en = 1'b0; r.vld = 1'b1; r.x_ready = 1'b0; r.x_rst = 1'b1;
      sched.push_back(r);
    end
    add_idle(1);
  endtask

  // Response monitor
  always @(posedge clk) begin
    #2;
    if (o_rsp_valid === 1'b1) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp at cycle %0d: got rsp_valid=1 err=%0b rdata=0x%0h expected none",
                 cyc, o_rsp_err, o_rsp_rdata);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("rsp_cycle", cyc, e.at);
        chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, e.err});
        chk("rsp_rdata", {24'd0, o_rsp_rdata}, {24'd0, e.rdata});
      end
    end
  end

  initial begin
    rec_t r;
    int kind;

    add_reset(2);
    add_idle(1);
    add_write(6'h0A, 8'h55, 0, 0);
    add_idle(1);
    add_read(6'h16, 8'hA5, 0, 0, 0);
    add_idle(1);
    add_write(6'h0A, 8'h55, 4, 4);
    add_idle(1);
    add_preempt(1'b1, 6'h0A, 8'h55, 0, 1'b0, 0, 3);
    add_idle(1);
    add_timeout(1'b0, 6'h2F, 8'h00);
    add_idle(1);
    add_write(6'h00, 8'hFF, 0, 0);
    add_write(6'h2F, 8'h00, 1, 2);
    add_reset_mid_read(6'h05, 8'h3C);

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0, 1: add_write(6'($urandom_range(0, 47)), 8'($urandom),
                        int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        2, 3: add_read(6'($urandom_range(0, 47)), 8'($urandom), int'($urandom_range(0, 5)),
                       int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        4: begin
          if ($urandom_range(0, 1) == 1)
            add_preempt(1'b1, 6'($urandom_range(0, 47)), 8'($urandom),
                        int'($urandom_range(0, 5)), 1'b1, int'($urandom_range(0, 5)),
                        int'($urandom_range(1, 4)));
          else
            add_preempt(1'($urandom), 6'($urandom_range(0, 47)), 8'($urandom),
                        int'($urandom_range(0, 5)), 1'b0, 0, int'($urandom_range(1, 4)));
        end
        default: add_timeout(1'($urandom), 6'($urandom_range(0, 47)), 8'($urandom));
      endcase
      add_idle(int'($urandom_range(0, 2)));
    end
    repeat (10) begin
      r = base();
      sched.push_back(r);
    end

    foreach (sched[k]) begin
      r = sched[k];
      @(posedge clk);
      #1;
      i_rst       = r.rst_n;
      i_en        = r.en;
      i_req_valid = r.vld;
      i_req_write = r.wr;
      i_req_addr  = r.addr;
      i_req_wdata = r.wd;
      i_dir       = r.dir;
      i_nxt       = r.nxt;
      i_data      = r.din;
      #1;
      chk("o_data", {24'd0, o_data}, {24'd0, r.x_data});
      chk("o_stp", {31'd0, o_stp}, {31'd0, r.x_stp});
      chk("o_req_ready", {31'd0, o_req_ready}, {31'd0, r.x_ready});
      if (r.x_rst) begin
        chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, o_rsp_rdata}, 32'd0);
      end
      if (r.lat >= 0) expq.push_back('{cyc + r.lat, r.r_err, r.r_data});
    end

    @(posedge clk);
    #5;
    chk("pending_rsp", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ulpi_reg_rw.md
Name: ulpi_reg_rw

Overview:
Link-side ULPI register-access engine that executes single immediate register writes and reads on the ULPI bus. It sits directly upstream of ulpi_ctrl: ulpi_ctrl grants the bus after PHY reset and stp sequencing, and this block then issues TX CMD register transactions. It is driven by a simple valid/ready request port and returns a one-cycle response.

Parameters:
NXT_TIMEOUT, 255, max cycles to wait for i_nxt or i_dir edges before aborting; 0 disables the timeout.

Ports:
i_clk  in  1  ULPI 60 MHz clock; all logic on rising edge.
i_rst  in  1  synchronous reset, active-low (0 = reset).
i_en  in  1  bus granted by ulpi_ctrl; requests are accepted only while 1.
i_req_valid  in  1  request present.
o_req_ready  out  1  request accepted this cycle when high with i_req_valid.
i_req_write  in  1  1 = register write, 0 = register read.
i_req_addr  in  6  immediate register address (0x00-0x2F).
i_req_wdata  in  8  write data.
o_rsp_valid  out  1  one-cycle response strobe.
o_rsp_rdata  out  8  read data; 0 for writes and errors.
o_rsp_err  out  1  transaction aborted (dir preempt or timeout).
i_dir  in  1  ULPI dir.
i_nxt  in  1  ULPI nxt.
o_stp  out  1  ULPI stp.
i_data  in  8  ULPI data from PHY.
o_data  out  8  ULPI data to PHY; 0x00 when idle.

Behaviour:
- Reset (i_rst=0 at an edge): state IDLE; o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_stp=0, o_data=0x00, timeout counter=0. Reset mid-transaction abandons it with no response.
- o_req_ready = (state==IDLE) & i_en & ~i_dir, combinational from registered state.
- Request fields are latched on accept. TX CMD byte: write = {2'b10, addr}, read = {2'b11, addr}.
- IDLE -> WR_CMD or RD_CMD on accept. o_data is driven with the TX CMD from the next cycle.
- WR_CMD: hold CMD until a cycle with i_nxt=1, then go to WR_DATA, driving wdata.
- WR_DATA: hold wdata until i_nxt=1, then go to WR_STP.
- WR_STP: o_stp=1 and o_data=0x00 for exactly one cycle. Then o_rsp_valid=1 with err=0, -> IDLE.
- RD_CMD: hold CMD until i_nxt=1, then go to RD_TURN with o_data=0x00.
- RD_TURN: expect i_dir=1 (turnaround cycle; ignore i_data), then go to RD_DATA.
- RD_DATA: capture i_data into rdata, then go to RD_TURN_BACK.
- RD_TURN_BACK: wait for i_dir=0. Then o_rsp_valid=1 with rdata and err=0, -> IDLE.
- Minimum latency from accept to o_rsp_valid: write 4 cycles (nxt immediate); read 5 cycles.
- Preemption: i_dir=1 while in WR_CMD, RD_CMD or WR_DATA without nxt means the PHY took the bus.
  - Stop driving: o_data=0x00.
  - Go to WAIT_DIR_LOW, then on i_dir=0 pulse o_rsp_valid with err=1 and return to IDLE.
  - If i_dir and i_nxt are both 1 in the CMD phase, treat it as preemption, not acceptance.
- Timeout: the counter resets on each state change and counts in the WR_CMD, WR_DATA, RD_CMD, RD_TURN and RD_TURN_BACK wait states.
  - Reaching NXT_TIMEOUT -> pulse o_stp one cycle, then err response via WAIT_DIR_LOW.
- i_en falling mid-transaction has no effect; the transaction completes. Only new accepts are blocked.
- o_stp is 1 only in WR_STP and in the timeout-abort cycle.
- o_rsp_valid is exactly one cycle per accepted request (absent reset).

Decomposition:
ulpi_pkg (shared with ulpi_ctrl):
- enum ulpi_reg_state_t {ULPI_REG_STATE_IDLE, _WR_CMD, _WR_DATA, _WR_STP, _RD_CMD, _RD_TURN, _RD_DATA, _RD_TURN_BACK, _WAIT_DIR_LOW, _ABORT_STP}.
- constants ULPI_TXCMD_REGWR=2'b10, ULPI_TXCMD_REGRD=2'b11, ULPI_DATA_IDLE=8'h00.

Single module, no sub-module. The timeout counter is inline.

Test Plan:
- Write happy path: i_rst=0 for 2 cycles then 1; write addr 0x0A data 0x55; nxt=1 on 2nd and 3rd driven cycles -> o_data 0x8A then 0x55; o_stp=1 one cycle with o_data=0x00; o_rsp_valid=1, err=0.
- Read happy path: read addr 0x16; nxt after CMD 0xD6; PHY dir=1 turnaround, i_data=0xA5, dir=0 -> o_rsp_valid=1, rdata=0xA5, err=0, o_stp never high.
- nxt stall: write with nxt delayed 5 cycles per phase -> 0x8A held 5 cycles, 0x55 held 5 cycles, response after 12 cycles; o_req_ready=0 throughout.
- Preemption: dir=1 during WR_CMD for 3 cycles -> o_data=0x00 next cycle, response err=1 one cycle after dir falls, no o_stp.
- Timeout: NXT_TIMEOUT=8, nxt never asserted on read -> after 8 CMD cycles o_stp=1 one cycle, then err=1, rdata=0x00.
- Reset mid-read: i_rst=0 during RD_TURN_BACK -> next cycle all outputs at reset values, no o_rsp_valid; i_req_valid held -> no accept while i_en=0.
